des_result_collector: RTL and testbench

//  Capture side of the DES datapath: buffers each 64-bit result the des core

---
 rtl/des_result_collector.sv | 163 ++++++++++++++++
 tb/tb_des_result_collector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_result_collector.sv
// -----------------------------------------------------------------------------
// des_result_collector
//
// Capture side of the DES datapath. Every 64-bit result the DES core emits
// (i_ciphertext qualified by i_dv) is buffered in a FIFO. Each entry is then
// read out as two 32-bit beats over a valid/ready interface: the high word
// first (o_last=0), then the low word (o_last=1).
//
// The DES core cannot be stalled. A result that arrives while the FIFO is
// full is dropped. Each drop sets the sticky o_overflow flag and increments
// the saturating o_drop_cnt counter.
//
// Ports
//   i_clk         clock; all logic runs on the rising edge
//   i_rst_n       synchronous, active-low reset
//   i_dv          result valid from the DES core
//   i_ciphertext  64-bit result from the DES core
//   o_rdata       32-bit readout beat (0 while empty)
//   o_rvalid      beat valid (FIFO not empty)
//   i_rready      reader accepts the current beat
//   o_last        1 = low-word (second) beat of an entry
//   o_level       number of stored entries, 0..DEPTH
//   o_full        o_level == DEPTH
//   o_empty       o_level == 0
//   o_overflow    sticky: at least one write was dropped
//   i_clr_ovf     clears o_overflow and o_drop_cnt
//   o_drop_cnt    number of dropped writes; saturates at all-ones
// -----------------------------------------------------------------------------
module des_result_collector #(
   parameter  int DEPTH = 16,
   parameter  int CNT_W = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_dv,
   input  logic [63:0]      i_ciphertext,
   output logic [31:0]      o_rdata,
   output logic             o_rvalid,
   input  logic             i_rready,
   output logic             o_last,
   output logic [AW:0]      o_level,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow,
   input  logic             i_clr_ovf,
   output logic [CNT_W-1:0] o_drop_cnt
);

   typedef enum logic {
      PH_HI,
      PH_LO
   } phase_t;

   logic [63:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   phase_t           r_phase;
   logic             r_overflow;
   logic [CNT_W-1:0] r_drop_cnt;

   logic             w_full;
   logic             w_empty;
   logic             w_wr;
   logic             w_drop;
   logic             w_beat;
   logic             w_pop;
   logic [63:0]      w_head;

   assign w_full  = (r_level == (AW+1)'(DEPTH));
   assign w_empty = (r_level == '0);

   // Fullness is the registered value: a drop is decided before any pop
   // that happens in the same cycle can free a slot.
   assign w_wr   = i_dv && !w_full;
   assign w_drop = i_dv && w_full;

   assign w_beat = !w_empty && i_rready;
   assign w_pop  = w_beat && (r_phase == PH_LO);

   assign w_head = r_mem[r_rd_ptr];

   // Storage has no reset; the pointers and the level define what is valid.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_wr) begin
         r_mem[r_wr_ptr] <= i_ciphertext;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Readout FSM: HI beat, then LO beat; the entry is popped on the LO beat.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_phase <= PH_HI;
      end else if (w_beat) begin
         case (r_phase)
            PH_HI:   r_phase <= PH_LO;
            PH_LO:   r_phase <= PH_HI;
            default: r_phase <= PH_HI;
         endcase
      end
   end

   // A drop in the same cycle as a clear wins: the flag stays set and the
   // counter restarts at one.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (i_clr_ovf) begin
            r_drop_cnt <= CNT_W'(1);
         end else if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end else if (i_clr_ovf) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   always_comb begin
      o_rdata = '0;
      o_last  = 1'b0;
      if (!w_empty) begin
         if (r_phase == PH_HI) begin
            o_rdata = w_head[63:32];
         end else begin
            o_rdata = w_head[31:0];
            o_last  = 1'b1;
         end
      end
   end

   assign o_rvalid   = !w_empty;
   assign o_level    = r_level;
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_overflow = r_overflow;
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_des_result_collector.sv
// -----------------------------------------------------------------------------
// tb_des_result_collector
//
// Scoreboard bench for des_result_collector. Each accepted write pushes its
// two expected beats (high word, then low word) onto a queue; each beat the
// reader accepts pops the front. Outputs are checked on the falling edge
// against the queue head and a small model of level, overflow and drop count.
// -----------------------------------------------------------------------------
module tb_des_result_collector;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
   localparam int AW    = $clog2(DEPTH);

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic             i_dv;
   logic [63:0]      i_ciphertext;
   logic [31:0]      o_rdata;
   logic             o_rvalid;
   logic             i_rready;
   logic             o_last;
   logic [AW:0]      o_level;
   logic             o_full;
   logic             o_empty;
   logic             o_overflow;
   logic             i_clr_ovf;
   logic [CNT_W-1:0] o_drop_cnt;

   des_result_collector #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_dv         (i_dv),
      .i_ciphertext (i_ciphertext),
      .o_rdata      (o_rdata),
      .o_rvalid     (o_rvalid),
      .i_rready     (i_rready),
      .o_last       (o_last),
      .o_level      (o_level),
      .o_full       (o_full),
      .o_empty      (o_empty),
      .o_overflow   (o_overflow),
      .i_clr_ovf    (i_clr_ovf),
      .o_drop_cnt   (o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   beat_t sb[$];
   int    m_level;
   logic  m_ovf;
   int    m_drop;
   logic  m_known;
   int    n_cmp;
   int    n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: check outputs on the falling edge, advance the model on the
   // rising edge, then leave #1 for the caller to drive the next inputs.
   task automatic step();
      beat_t b;
      @(negedge i_clk);
      if (m_known) begin
         chk("rvalid", 64'(o_rvalid), 64'(m_level != 0));
         if (m_level != 0) begin
            chk("rdata", 64'(o_rdata), 64'(sb[0].d));
            chk("last",  64'(o_last),  64'(sb[0].l));
         end else begin
            chk("rdata_empty", 64'(o_rdata), 64'd0);
            chk("last_empty",  64'(o_last),  64'd0);
         end
         chk("level",    64'(o_level),    64'(m_level));
         chk("full",     64'(o_full),     64'(m_level == DEPTH));
         chk("empty",    64'(o_empty),    64'(m_level == 0));
         chk("overflow", 64'(o_overflow), 64'(m_ovf));
         chk("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
      end
      @(posedge i_clk);
      if (!i_rst_n) begin
         m_known = 1'b1;
         sb.delete();
         m_level = 0;
         m_ovf   = 1'b0;
         m_drop  = 0;
      end else if (m_known) begin
         logic full_now;
         full_now = (m_level == DEPTH);
         if (m_level != 0 && i_rready) begin
            b = sb.pop_front();
            if (b.l) m_level--;
         end
         if (i_dv && !full_now) begin
            sb.push_back('{d: i_ciphertext[63:32], l: 1'b0});
            sb.push_back('{d: i_ciphertext[31:0],  l: 1'b1});
            m_level++;
         end
         if (i_dv && full_now) begin
            m_ovf  = 1'b1;
            m_drop = i_clr_ovf ? 1 : ((m_drop == 65535) ? m_drop : m_drop + 1);
         end else if (i_clr_ovf) begin
            m_ovf  = 1'b0;
            m_drop = 0;
         end
      end
      #1;
   endtask

   task automatic cyc(input logic dv, input logic [63:0] data, input logic rdy, input logic clr);
      i_dv         = dv;
      i_ciphertext = data;
      i_rready     = rdy;
      i_clr_ovf    = clr;
      step();
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      m_known = 1'b0;
      m_level = 0;
      m_ovf   = 1'b0;
      m_drop  = 0;

      // 1: reset held two cycles with i_dv high
      i_rst_n = 1'b0;
      cyc(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
      cyc(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
      i_rst_n = 1'b1;
      chk("t1_level",  64'(o_level),    64'd0);
      chk("t1_rvalid", 64'(o_rvalid),   64'd0);
      chk("t1_rdata",  64'(o_rdata),    64'd0);
      chk("t1_ovf",    64'(o_overflow), 64'd0);
      chk("t1_drop",   64'(o_drop_cnt), 64'd0);

      // 2: single entry, reader always ready
      cyc(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
      chk("t2_hi",     64'(o_rdata), 64'h0123_4567);
      chk("t2_hilast", 64'(o_last),  64'd0);
      chk("t2_lvl1",   64'(o_level), 64'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t2_lo",     64'(o_rdata), 64'h89AB_CDEF);
      chk("t2_lolast", 64'(o_last),  64'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t2_lvl0",   64'(o_level), 64'd0);

      // 3: 18 writes with reader stalled, then drain
      for (int i = 0; i < 18; i++) begin
         cyc(1'b1, {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)}, 1'b0, 1'b0);
         if (i == 15) chk("t3_full", 64'(o_full), 64'd1);
      end
      chk("t3_ovf",  64'(o_overflow), 64'd1);
      chk("t3_drop", 64'(o_drop_cnt), 64'd2);
      chk("t3_lvl",  64'(o_level),    64'd16);
      for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t3_empty", 64'(o_empty), 64'd1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("t3_clr_ovf",  64'(o_overflow), 64'd0);
      chk("t3_clr_drop", 64'(o_drop_cnt), 64'd0);

      // 4: reader toggles ready every cycle
      for (int i = 0; i < 4; i++) cyc(1'b1, rnd64(), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'(i % 2), 1'b0);
      chk("t4_empty", 64'(o_empty), 64'd1);

      // 5: write coinciding with a LO-beat pop, then a long stream with wrap
      for (int i = 0; i < 5; i++) cyc(1'b1, rnd64(), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, rnd64(), 1'b1, 1'b0);
      chk("t5_lvl5", 64'(o_level), 64'd5);
      for (int i = 0; i < 80; i++) cyc(1'(i % 2 == 0), rnd64(), 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t5_empty", 64'(o_empty), 64'd1);

      // 6: drop together with clear -> set wins
      for (int i = 0; i < 16; i++) cyc(1'b1, rnd64(), 1'b0, 1'b0);
      cyc(1'b1, rnd64(), 1'b0, 1'b0);
      chk("t6_drop1", 64'(o_drop_cnt), 64'd1);
      cyc(1'b1, rnd64(), 1'b0, 1'b1);
      chk("t6_setwin_ovf",  64'(o_overflow), 64'd1);
      chk("t6_setwin_drop", 64'(o_drop_cnt), 64'd1);

      // 6: reset between HI and LO beats
      i_rst_n = 1'b0;
      cyc(1'b0, '0, 1'b0, 1'b0);
      i_rst_n = 1'b1;
      cyc(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t6_lo_pending", 64'(o_rdata), 64'h3333_4444);
      i_rst_n = 1'b0;
      cyc(1'b0, '0, 1'b1, 1'b0);
      i_rst_n = 1'b1;
      chk("t6_rst_empty", 64'(o_empty), 64'd1);
      cyc(1'b1, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
      chk("t6_hi_after_rst", 64'(o_rdata), 64'h5555_6666);
      chk("t6_last_after_rst", 64'(o_last), 64'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
